// File: rtl/sdram_ctrl_fsm.sv
// SDRAM sequencer: power-up init chain, periodic auto-refresh and read/write burst FSM.
// Drives the command-decode stage via init_state/work_state/cnt_clk/sys_r_wn.
module sdram_ctrl_fsm #(
    parameter int T_INIT  = 10000,
    parameter int T_RP    = 2,
    parameter int T_RFC   = 4,
    parameter int T_MRD   = 2,
    parameter int T_RCD   = 2,
    parameter int CAS_LAT = 3,
    parameter int T_DAL   = 3,
    parameter int T_REF   = 390
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sdram_wr_req,
    input  logic       sdram_rd_req,
    input  logic [8:0] sdwr_byte,
    input  logic [8:0] sdrd_byte,
    output logic [3:0] init_state,
    output logic [3:0] work_state,
    output logic [8:0] cnt_clk,
    output logic       sys_r_wn,
    output logic       sdram_wr_ack,
    output logic       sdram_rd_ack,
    output logic       sdram_init_done,
    output logic       sdram_busy
);

    typedef enum logic [3:0] {
        I_NOP  = 4'd0,
        I_PRE  = 4'd1,
        I_TRP  = 4'd2,
        I_AR1  = 4'd3,
        I_TRF1 = 4'd4,
        I_AR2  = 4'd5,
        I_TRF2 = 4'd6,
        I_MRS  = 4'd7,
        I_TMRD = 4'd8,
        I_DONE = 4'd9
    } init_st_t;

    typedef enum logic [3:0] {
        W_IDLE   = 4'd0,
        W_ACTIVE = 4'd1,
        W_TRCD   = 4'd2,
        W_READ   = 4'd3,
        W_CL     = 4'd4,
        W_RD     = 4'd5,
        W_RWAIT  = 4'd6,
        W_WRITE  = 4'd7,
        W_WD     = 4'd8,
        W_TDAL   = 4'd9,
        W_AR     = 4'd10,
        W_TRFC   = 4'd11
    } work_st_t;

    localparam int REF_W = (T_REF > 1) ? $clog2(T_REF) : 1;

    // Last cnt_clk value of each wait; ACTIVE supplies one of the T_RCD cycles.
    localparam logic [8:0]       C_TRP_END  = 9'(T_RP - 1);
    localparam logic [8:0]       C_TRFC_END = 9'(T_RFC - 1);
    localparam logic [8:0]       C_TMRD_END = 9'(T_MRD - 1);
    localparam logic [8:0]       C_TRCD_END = 9'(T_RCD - 2);
    localparam logic [8:0]       C_CL_END   = 9'(CAS_LAT - 2);
    localparam logic [8:0]       C_TDAL_END = 9'(T_DAL - 1);
    localparam logic [14:0]      C_INIT_END = 15'(T_INIT - 1);
    localparam logic [REF_W-1:0] C_REF_END  = REF_W'(T_REF - 1);

    init_st_t          r_init_state;
    work_st_t          r_work_state;
    logic [8:0]        r_cnt;
    logic [14:0]       r_init_cnt;
    logic [REF_W-1:0]  r_ref_cnt;
    logic              r_ref_pend;
    logic              r_r_wn;
    logic [8:0]        r_burst;

    init_st_t          w_init_next;
    work_st_t          w_work_next;
    logic              w_state_chg;
    logic              w_ref_wrap;
    logic              w_start;
    logic [8:0]        w_wr_len;
    logic [8:0]        w_rd_len;

    assign w_wr_len    = (sdwr_byte == '0) ? 9'd1 : sdwr_byte;
    assign w_rd_len    = (sdrd_byte == '0) ? 9'd1 : sdrd_byte;
    assign w_state_chg = (w_init_next != r_init_state) || (w_work_next != r_work_state);
    assign w_ref_wrap  = (r_init_state == I_DONE) && (r_ref_cnt == C_REF_END);
    assign w_start     = (r_work_state == W_IDLE) && (w_work_next == W_ACTIVE);

    always_comb begin
        w_init_next = r_init_state;
        case (r_init_state)
            I_NOP:   if (r_init_cnt == C_INIT_END) w_init_next = I_PRE;
            I_PRE:   w_init_next = I_TRP;
            I_TRP:   if (r_cnt == C_TRP_END) w_init_next = I_AR1;
            I_AR1:   w_init_next = I_TRF1;
            I_TRF1:  if (r_cnt == C_TRFC_END) w_init_next = I_AR2;
            I_AR2:   w_init_next = I_TRF2;
            I_TRF2:  if (r_cnt == C_TRFC_END) w_init_next = I_MRS;
            I_MRS:   w_init_next = I_TMRD;
            I_TMRD:  if (r_cnt == C_TMRD_END) w_init_next = I_DONE;
            I_DONE:  w_init_next = I_DONE;
            default: w_init_next = I_NOP;
        endcase
    end

    always_comb begin
        w_work_next = r_work_state;
        case (r_work_state)
            W_IDLE: begin
                if (r_init_state == I_DONE) begin
                    if (r_ref_pend)
                        w_work_next = W_AR;
                    else if (sdram_wr_req || sdram_rd_req)
                        w_work_next = W_ACTIVE;
                end
            end
            W_ACTIVE: w_work_next = W_TRCD;
            W_TRCD:   if (r_cnt == C_TRCD_END) w_work_next = r_r_wn ? W_READ : W_WRITE;
            W_READ:   w_work_next = W_CL;
            W_CL:     if (r_cnt == C_CL_END) w_work_next = W_RD;
            W_RD:     if (r_cnt == r_burst - 9'd1) w_work_next = W_RWAIT;
            W_RWAIT:  if (r_cnt == C_TRP_END) w_work_next = W_IDLE;
            // WRITE carries the first word, so WD covers the remaining burst-1.
            W_WRITE:  w_work_next = (r_burst == 9'd1) ? W_TDAL : W_WD;
            W_WD:     if (r_cnt == r_burst - 9'd2) w_work_next = W_TDAL;
            W_TDAL:   if (r_cnt == C_TDAL_END) w_work_next = W_IDLE;
            W_AR:     w_work_next = W_TRFC;
            W_TRFC:   if (r_cnt == C_TRFC_END) w_work_next = W_IDLE;
            default:  w_work_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_state <= I_NOP;
            r_work_state <= W_IDLE;
            r_cnt        <= '0;
            r_init_cnt   <= '0;
        end else begin
            r_init_state <= w_init_next;
            r_work_state <= w_work_next;
            if (w_state_chg)
                r_cnt <= '0;
            else if (r_cnt != '1)
                r_cnt <= r_cnt + 9'd1;
            if (r_init_state == I_NOP && r_init_cnt != C_INIT_END)
                r_init_cnt <= r_init_cnt + 15'd1;
        end
    end

    // A wrap coinciding with entry to AR keeps the flag set so that refresh is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref_cnt  <= '0;
            r_ref_pend <= 1'b0;
        end else begin
            if (r_init_state == I_DONE)
                r_ref_cnt <= w_ref_wrap ? '0 : r_ref_cnt + 1'b1;
            if (w_ref_wrap)
                r_ref_pend <= 1'b1;
            else if (r_work_state != W_AR && w_work_next == W_AR)
                r_ref_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r_wn  <= 1'b1;
            r_burst <= 9'd1;
        end else if (w_start) begin
            if (sdram_wr_req) begin
                r_r_wn  <= 1'b0;
                r_burst <= w_wr_len;
            end else begin
                r_r_wn  <= 1'b1;
                r_burst <= w_rd_len;
            end
        end
    end

    assign init_state      = r_init_state;
    assign work_state      = r_work_state;
    assign cnt_clk         = r_cnt;
    assign sys_r_wn        = r_r_wn;
    assign sdram_wr_ack    = (r_work_state == W_WRITE) || (r_work_state == W_WD);
    assign sdram_rd_ack    = (r_work_state == W_RD);
    assign sdram_init_done = (r_init_state == I_DONE);
    assign sdram_busy      = !((r_init_state == I_DONE) && (r_work_state == W_IDLE) && !r_ref_pend);

endmodule
